// File: rtl/seq_detect_pkg.sv
// Shared types and elaboration-time helpers for the parametrised serial pattern detector.
// The next-state table is built once from the pattern using a KMP failure function.
package seq_detect_pkg;

  localparam int unsigned MaxPatLen = 16;
  localparam int unsigned NsEntryW  = 5;
  localparam int unsigned NsEntries = 2 * (MaxPatLen + 1);

  // Flattened table: entry (2*state + bit) holds the next state index.
  typedef logic [NsEntries*NsEntryW-1:0] ns_table_t;

  function automatic int unsigned state_width(int unsigned pat_len);
    return $clog2(pat_len + 1);
  endfunction

  function automatic int unsigned get_entry(ns_table_t v, int unsigned idx);
    return 32'(NsEntryW'(v >> (idx * NsEntryW)));
  endfunction

  function automatic ns_table_t set_entry(ns_table_t v, int unsigned idx, int unsigned val);
    return v | (ns_table_t'(val) << (idx * NsEntryW));
  endfunction

  function automatic logic bit_at(logic [MaxPatLen-1:0] v, int unsigned idx);
    return ((v >> idx) & MaxPatLen'(1)) != '0;
  endfunction

  function automatic ns_table_t build_next_state(logic [MaxPatLen-1:0] pattern,
                                                 int unsigned pat_len, logic overlap);
    ns_table_t             tbl;
    ns_table_t             fail;
    logic [MaxPatLen-1:0]  p;
    int unsigned           j;
    int unsigned           nxt;
    tbl  = '0;
    fail = '0;
    p    = '0;
    // p[i] is the i-th bit received, i.e. the pattern read MSB first.
    for (int unsigned i = 0; i < pat_len; i++) begin
      if (bit_at(pattern, pat_len - 1 - i)) p = p | (MaxPatLen'(1) << i);
    end
    for (int unsigned i = 1; i < pat_len; i++) begin
      j = get_entry(fail, i);
      while (j > 0 && bit_at(p, i) != bit_at(p, j)) j = get_entry(fail, j);
      if (bit_at(p, i) == bit_at(p, j)) j = j + 1;
      fail = set_entry(fail, i + 1, j);
    end
    for (int unsigned k = 0; k <= pat_len; k++) begin
      for (int unsigned b = 0; b < 2; b++) begin
        if (k < pat_len && bit_at(p, k) == (b != 0)) nxt = k + 1;
        else if (k == 0)                               nxt = 0;
        else if (k == pat_len && !overlap)             nxt = get_entry(tbl, b);
        else                                           nxt = get_entry(tbl, 2 * get_entry(fail, k) + b);
        tbl = set_entry(tbl, 2 * k + b, nxt);
      end
    end
    return tbl;
  endfunction

endpackage

// File: rtl/seq_detect_moore_param_if.sv
// Serial input, qualifier/clear controls and detector status outputs.
interface seq_detect_moore_param_if #(
  parameter int unsigned PAT_LEN = 3,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned SW = seq_detect_pkg::state_width(PAT_LEN);

  logic             E;
  logic             EN;
  logic             CNT_CLR;
  logic             Q;
  logic [SW-1:0]    STATE;
  logic [CNT_W-1:0] MATCH_CNT;

  modport master (output E, EN, CNT_CLR, input Q, STATE, MATCH_CNT);
  modport slave  (input E, EN, CNT_CLR, output Q, STATE, MATCH_CNT);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and a clear that beats increment.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] MaxCount = '1;

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)                              count_d = '0;
    else if (inc && count_q != MaxCount)  count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/seq_detect_moore_param.sv
// Moore serial pattern detector: STATE counts matched pattern bits, Q flags a full match.
// The transition table is computed at elaboration, so the runtime logic is a single lookup.
module seq_detect_moore_param #(
  parameter int unsigned          PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0]   PATTERN = 3'b011,
  parameter logic                 OVERLAP = 1'b1,
  parameter int unsigned          CNT_W   = 8
) (
  input logic                      CLK,
  input logic                      RST_N,
  seq_detect_moore_param_if.slave  bus
);
  import seq_detect_pkg::*;

  if (PAT_LEN < 1 || PAT_LEN > MaxPatLen) begin : g_bad_pat_len
    $error("PAT_LEN must be in 1..16");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("CNT_W must be in 1..32");
  end

  localparam int unsigned      SW        = state_width(PAT_LEN);
  localparam ns_table_t        NsTable   = build_next_state(MaxPatLen'(PATTERN), PAT_LEN,
                                                            OVERLAP);
  localparam logic [SW-1:0]    FullState = SW'(PAT_LEN);

  logic [SW-1:0]    state_q, state_d;
  logic             q_q, q_d;
  logic             hit;
  logic [CNT_W-1:0] match_cnt;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    hit     = 1'b0;
    if (bus.EN) begin
      // Encodings above PAT_LEN are unreachable; fall back to the idle state.
      if (state_q > FullState) begin
        state_d = '0;
      end else begin
        state_d = SW'(NsTable >> ((32'(state_q) * 2 + 32'(bus.E)) * NsEntryW));
      end
      q_d = (state_d == FullState);
      hit = q_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= '0;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc   (hit),
    .clr   (bus.CNT_CLR),
    .count (match_cnt)
  );

  assign bus.Q         = q_q;
  assign bus.STATE     = state_q;
  assign bus.MATCH_CNT = match_cnt;
endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Five detector configurations share one input stream; a history-based matcher predicts outputs.
module tb_seq_detect_moore_param;
  localparam int NDut = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, e, en, clr;

  seq_detect_moore_param_if #(.PAT_LEN(3), .CNT_W(8)) if0 ();
  seq_detect_moore_param_if #(.PAT_LEN(3), .CNT_W(8)) if1 ();
  seq_detect_moore_param_if #(.PAT_LEN(3), .CNT_W(8)) if2 ();
  seq_detect_moore_param_if #(.PAT_LEN(1), .CNT_W(2)) if3 ();
  seq_detect_moore_param_if #(.PAT_LEN(4), .CNT_W(8)) if4 ();

  assign if0.E = e;  assign if0.EN = en;  assign if0.CNT_CLR = clr;
  assign if1.E = e;  assign if1.EN = en;  assign if1.CNT_CLR = clr;
  assign if2.E = e;  assign if2.EN = en;  assign if2.CNT_CLR = clr;
  assign if3.E = e;  assign if3.EN = en;  assign if3.CNT_CLR = clr;
  assign if4.E = e;  assign if4.EN = en;  assign if4.CNT_CLR = clr;

  seq_detect_moore_param #(.PAT_LEN(3), .PATTERN(3'b011), .OVERLAP(1'b1), .CNT_W(8))
    u_d0 (.CLK(clk), .RST_N(rst_n), .bus(if0));
  seq_detect_moore_param #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(8))
    u_d1 (.CLK(clk), .RST_N(rst_n), .bus(if1));
  seq_detect_moore_param #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8))
    u_d2 (.CLK(clk), .RST_N(rst_n), .bus(if2));
  seq_detect_moore_param #(.PAT_LEN(1), .PATTERN(1'b1), .OVERLAP(1'b1), .CNT_W(2))
    u_d3 (.CLK(clk), .RST_N(rst_n), .bus(if3));
  seq_detect_moore_param #(.PAT_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(8))
    u_d4 (.CLK(clk), .RST_N(rst_n), .bus(if4));

  logic [31:0] act_state [NDut];
  logic [31:0] act_q     [NDut];
  logic [31:0] act_cnt   [NDut];
  assign act_state[0] = 32'(if0.STATE);  assign act_q[0] = 32'(if0.Q);
  assign act_state[1] = 32'(if1.STATE);  assign act_q[1] = 32'(if1.Q);
  assign act_state[2] = 32'(if2.STATE);  assign act_q[2] = 32'(if2.Q);
  assign act_state[3] = 32'(if3.STATE);  assign act_q[3] = 32'(if3.Q);
  assign act_state[4] = 32'(if4.STATE);  assign act_q[4] = 32'(if4.Q);
  assign act_cnt[0] = 32'(if0.MATCH_CNT);
  assign act_cnt[1] = 32'(if1.MATCH_CNT);
  assign act_cnt[2] = 32'(if2.MATCH_CNT);
  assign act_cnt[3] = 32'(if3.MATCH_CNT);
  assign act_cnt[4] = 32'(if4.MATCH_CNT);

  // Reference configuration and state: the model keeps the raw bit history since reset
  // (or since the last match when overlap is off) and searches it for the longest prefix.
  int unsigned cfg_len [NDut] = '{3, 3, 3, 1, 4};
  logic [31:0] cfg_pat [NDut] = '{32'h3, 32'h5, 32'h5, 32'h1, 32'hF};
  logic        cfg_ov  [NDut] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  int unsigned cfg_max [NDut] = '{255, 255, 255, 3, 255};

  logic [31:0] m_hist   [NDut];
  int unsigned m_nvalid [NDut];
  int unsigned m_state  [NDut];
  int unsigned m_cnt    [NDut];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int unsigned longest(logic [31:0] hist, int unsigned nvalid,
                                          int unsigned len, logic [31:0] pat);
    logic ok;
    for (int unsigned k = len; k >= 1; k--) begin
      if (k <= nvalid) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < k; i++) begin
          if (((hist >> (k - 1 - i)) & 32'd1) != ((pat >> (len - 1 - i)) & 32'd1)) ok = 1'b0;
        end
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  task automatic model_step();
    logic inc;
    for (int d = 0; d < NDut; d++) begin
      if (!rst_n) begin
        m_hist[d] = '0; m_nvalid[d] = 0; m_state[d] = 0; m_cnt[d] = 0;
      end else begin
        inc = 1'b0;
        if (en) begin
          m_hist[d]   = {m_hist[d][30:0], e};
          m_nvalid[d] = (m_nvalid[d] < 32) ? m_nvalid[d] + 1 : 32;
          m_state[d]  = longest(m_hist[d], m_nvalid[d], cfg_len[d], cfg_pat[d]);
          if (m_state[d] == cfg_len[d]) begin
            inc = 1'b1;
            if (!cfg_ov[d]) m_nvalid[d] = 0;
          end
        end
        if (clr)                             m_cnt[d] = 0;
        else if (inc && m_cnt[d] < cfg_max[d]) m_cnt[d] = m_cnt[d] + 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step(input logic r, input logic en_v, input logic e_v, input logic clr_v);
    rst_n = r; en = en_v; e = e_v; clr = clr_v;
    @(posedge clk);
    model_step();
    #1;
    for (int d = 0; d < NDut; d++) begin
      check($sformatf("model d%0d state", d), act_state[d], m_state[d]);
      check($sformatf("model d%0d q", d), act_q[d], 32'(m_state[d] == cfg_len[d]));
      check($sformatf("model d%0d cnt", d), act_cnt[d], m_cnt[d]);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        e;
    logic        clr;
    int          dut;
    int unsigned st;
    logic        q;
    int unsigned cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic en_v, logic e_v, logic clr_v, int dut,
                              int unsigned st, logic q, int unsigned cnt);
    vec_t v;
    v.rst_n = r; v.en = en_v; v.e = e_v; v.clr = clr_v;
    v.dut = dut; v.st = st; v.q = q; v.cnt = cnt;
    return v;
  endfunction

  task automatic expect_dut(input string name, input int d, input int unsigned st,
                            input logic q, input int unsigned cnt);
    check({name, " state"}, act_state[d], st);
    check({name, " q"}, act_q[d], 32'(q));
    check({name, " cnt"}, act_cnt[d], cnt);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; e = 1'b0; clr = 1'b0;

    // 011 overlap: 0,1,1,0,1,1
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 2, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 3, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 2, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 3, 1, 2));
    // 101 overlap: 1,0,1,0,1
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 2, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 1, 3, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 1, 2, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 1, 3, 1, 2));
    // 011 with a four-cycle stall after 0,1
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 2, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 3, 1, 1));
    // single-bit pattern, 2-bit counter saturates, then clear wins over increment
    vecs.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 3, 1, 1, 1));
    vecs.push_back(mk(1, 1, 1, 0, 3, 1, 1, 2));
    vecs.push_back(mk(1, 1, 1, 0, 3, 1, 1, 3));
    vecs.push_back(mk(1, 1, 1, 0, 3, 1, 1, 3));
    vecs.push_back(mk(1, 1, 1, 0, 3, 1, 1, 3));
    vecs.push_back(mk(1, 1, 1, 1, 3, 1, 1, 0));
    // 011: reset mid-sequence discards the partial match
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0));
    // 1111 overlap: six ones
    vecs.push_back(mk(0, 0, 0, 0, 4, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 4, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 4, 2, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 4, 3, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 4, 4, 1, 1));
    vecs.push_back(mk(1, 1, 1, 0, 4, 4, 1, 2));
    vecs.push_back(mk(1, 1, 1, 0, 4, 4, 1, 3));

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].en, vecs[i].e, vecs[i].clr);
      expect_dut($sformatf("vec%0d", i), vecs[i].dut, vecs[i].st, vecs[i].q, vecs[i].cnt);
    end

    // 101 without overlap: the trailing 0,1 starts a fresh search
    step(0, 0, 0, 0); expect_dut("noov rst", 2, 0, 0, 0);
    step(1, 1, 1, 0); expect_dut("noov b1", 2, 1, 0, 0);
    step(1, 1, 0, 0); expect_dut("noov b2", 2, 2, 0, 0);
    step(1, 1, 1, 0); expect_dut("noov b3", 2, 3, 1, 1);
    step(1, 1, 0, 0); expect_dut("noov b4", 2, 0, 0, 1);
    step(1, 1, 1, 0); expect_dut("noov b5", 2, 1, 0, 1);

    // 011: clear on the completing edge leaves the count at zero while Q rises
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    step(1, 1, 1, 1); expect_dut("clr vs inc", 0, 3, 1, 0);

    step(0, 0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      step(logic'($urandom_range(0, 63) != 0), logic'($urandom_range(0, 3) != 0),
           1'($urandom), logic'($urandom_range(0, 31) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
